// File: rtl/bip_pkg.sv
// Shared BIP definitions: execution controller state encoding and the HLT
// opcode constant. The CPU decoder uses the same opcode constants.
package bip_pkg;

  localparam int LEN_OPCODE = 5;
  localparam logic [LEN_OPCODE-1:0] HLT_OPCODE = 5'b00000;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLR   = 3'd1,
    S_RUN   = 3'd2,
    S_PAUSE = 3'd3,
    S_STEP  = 3'd4,
    S_HALT  = 3'd5
  } state_t;

  // The CPU is frozen in these states, so PC/ACC snapshots are taken here.
  function automatic logic is_frozen(state_t s);
    return (s == S_PAUSE) || (s == S_HALT);
  endfunction

endpackage

// File: rtl/bip_exec_ctrl_if.sv
// Bus between the BIP top level / CPU and the execution controller.
//
// Control semantics: start and step are single-cycle pulses. They are sampled
// on a rising clk edge and act on the state held at that edge. There is no
// back-pressure. start always wins over step and mode. A step that arrives
// outside PAUSE is dropped. cpu_en is the only output that depends
// combinationally on an input (instr). Every other output is a register.
interface bip_exec_ctrl_if
  import bip_pkg::*;
#(
  parameter int len_addr   = 11,
  parameter int len_data   = 16,
  parameter int len_cycles = 32
) ();

  logic                  start;
  logic                  step;
  logic                  mode;
  logic [len_data-1:0]   instr;
  logic [len_addr-1:0]   pc;
  logic [len_data-1:0]   acc;

  logic                  cpu_en;
  logic                  cpu_rst;
  logic                  busy;
  logic                  halted;
  logic [len_cycles-1:0] cycle_count;
  logic [len_addr-1:0]   pc_snap;
  logic [len_data-1:0]   acc_snap;
  logic                  snap_valid;

  // Debug visibility: the FSM state and the counter saturation flag.
  state_t                state_dbg;
  logic                  cnt_sat_dbg;

  modport master (
    output start, step, mode, instr, pc, acc,
    input  cpu_en, cpu_rst, busy, halted, cycle_count,
           pc_snap, acc_snap, snap_valid, state_dbg, cnt_sat_dbg
  );

  modport slave (
    input  start, step, mode, instr, pc, acc,
    output cpu_en, cpu_rst, busy, halted, cycle_count,
           pc_snap, acc_snap, snap_valid, state_dbg, cnt_sat_dbg
  );

endinterface

// File: rtl/bip_sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
// A synchronous clear has priority over the count enable.
module bip_sat_counter #(
  parameter int width = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr_i,
  input  logic             en_i,
  output logic [width-1:0] count_o,
  output logic             sat_o
);

  logic [width-1:0] count_q;
  logic [width-1:0] count_d;

  assign sat_o   = &count_q;
  assign count_o = count_q;

  // Next count: clear, else increment unless already saturated.
  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i && !sat_o) begin
      count_d = count_q + 1'b1;
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/bip_exec_ctrl.sv
// BIP execution controller. It gates the CPU clock-enable, handles free-run
// and single-step operation, and stops the CPU before a HLT executes. It also
// counts executed cycles and snapshots PC/ACC while the CPU is frozen.
module bip_exec_ctrl
  import bip_pkg::*;
#(
  parameter int                    len_addr    = 11,
  parameter int                    len_data    = 16,
  parameter int                    len_opcode  = LEN_OPCODE,
  parameter int                    len_cycles  = 32,
  parameter logic [len_opcode-1:0] halt_opcode = HLT_OPCODE
) (
  input  logic         clk,
  input  logic         reset,
  bip_exec_ctrl_if.slave bus
);

  // The opcode sits in the top bits of the instruction. The shift keeps the
  // comparison full-width.
  localparam logic [len_data-1:0] HALT_WORD = len_data'(halt_opcode);

  state_t              state_q, state_d;
  logic                cpu_rst_q, busy_q, halted_q;
  logic [len_addr-1:0] pc_snap_q;
  logic [len_data-1:0] acc_snap_q;
  logic                snap_valid_q;
  logic                is_halt;
  logic                cpu_en;

  assign is_halt = ((bus.instr >> (len_data - len_opcode)) == HALT_WORD);

  // The CPU advances in RUN unless the fetched word is HLT. STEP always
  // advances, because it is only entered when the instruction is not HLT.
  assign cpu_en = ((state_q == S_RUN) && !is_halt) || (state_q == S_STEP);

  // Next-state logic. start overrides everything once the controller has left IDLE.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (bus.start) state_d = S_CLR;
      S_CLR:   state_d = bus.mode ? S_PAUSE : S_RUN;
      S_RUN: begin
        if (bus.start)      state_d = S_CLR;
        else if (is_halt)   state_d = S_HALT;
        else if (bus.mode)  state_d = S_PAUSE;
      end
      S_PAUSE: begin
        if (bus.start)                 state_d = S_CLR;
        else if (bus.step && !is_halt) state_d = S_STEP;
        else if (bus.step && is_halt)  state_d = S_HALT;
        else if (!bus.mode)            state_d = S_RUN;
      end
      S_STEP:  state_d = bus.start ? S_CLR : S_PAUSE;
      S_HALT:  if (bus.start) state_d = S_CLR;
      default: state_d = S_IDLE;
    endcase
  end

  // State register. The status outputs are registered from the next state,
  // so they stay glitch-free and line up with state_q.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cpu_rst_q <= 1'b1;
      busy_q    <= 1'b0;
      halted_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cpu_rst_q <= (state_d == S_IDLE) || (state_d == S_CLR);
      busy_q    <= (state_d == S_CLR) || (state_d == S_RUN) || (state_d == S_STEP);
      halted_q  <= (state_d == S_HALT);
    end
  end

  // Snapshot PC/ACC in every frozen cycle. CLR drops only the valid flag, so
  // the old values remain readable until the next freeze.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_snap_q    <= '0;
      acc_snap_q   <= '0;
      snap_valid_q <= 1'b0;
    end else if (state_q == S_CLR) begin
      snap_valid_q <= 1'b0;
    end else if (is_frozen(state_q)) begin
      pc_snap_q    <= bus.pc;
      acc_snap_q   <= bus.acc;
      snap_valid_q <= 1'b1;
    end
  end

  bip_sat_counter #(
    .width (len_cycles)
  ) u_cycle_cnt (
    .clk     (clk),
    .reset   (reset),
    .clr_i   (state_q == S_CLR),
    .en_i    (cpu_en),
    .count_o (bus.cycle_count),
    .sat_o   (bus.cnt_sat_dbg)
  );

  assign bus.cpu_en     = cpu_en;
  assign bus.cpu_rst    = cpu_rst_q;
  assign bus.busy       = busy_q;
  assign bus.halted     = halted_q;
  assign bus.pc_snap    = pc_snap_q;
  assign bus.acc_snap   = acc_snap_q;
  assign bus.snap_valid = snap_valid_q;
  assign bus.state_dbg  = state_q;

endmodule

// File: tb/tb_bip_exec_ctrl.sv
// Directed bench for bip_exec_ctrl. A tiny CPU model advances PC/ACC on
// cpu_en and clears them on cpu_rst. Program: six non-HLT words, then HLT at
// address 6. A second instance with a 4-bit cycle counter exercises saturation.
module tb_bip_exec_ctrl;
  import bip_pkg::*;

  logic clk = 1'b0;
  logic reset;
  logic rst4;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  bip_exec_ctrl_if #(.len_addr(11), .len_data(16), .len_cycles(32)) bif ();
  bip_exec_ctrl_if #(.len_addr(11), .len_data(16), .len_cycles(4))  bif4 ();

  bip_exec_ctrl #(.len_cycles(32)) dut  (.clk(clk), .reset(reset), .bus(bif));
  bip_exec_ctrl #(.len_cycles(4))  dut4 (.clk(clk), .reset(rst4),  .bus(bif4));

  // CPU models: PC +1 and ACC +0x11 per executed instruction.
  logic [15:0] prog [0:15];
  logic [10:0] cpu_pc   = '0;
  logic [15:0] cpu_acc  = '0;
  logic [10:0] cpu4_pc  = '0;
  logic [15:0] cpu4_acc = '0;

  always_ff @(posedge clk) begin
    if (bif.cpu_rst) begin
      cpu_pc  <= '0;
      cpu_acc <= '0;
    end else if (bif.cpu_en) begin
      cpu_pc  <= cpu_pc + 11'd1;
      cpu_acc <= cpu_acc + 16'h0011;
    end
  end

  always_ff @(posedge clk) begin
    if (bif4.cpu_rst) begin
      cpu4_pc  <= '0;
      cpu4_acc <= '0;
    end else if (bif4.cpu_en) begin
      cpu4_pc  <= cpu4_pc + 11'd1;
      cpu4_acc <= cpu4_acc + 16'h0011;
    end
  end

  assign bif.pc     = cpu_pc;
  assign bif.acc    = cpu_acc;
  assign bif.instr  = prog[cpu_pc[3:0]];
  assign bif4.pc    = cpu4_pc;
  assign bif4.acc   = cpu4_acc;
  assign bif4.instr = 16'hF800;

  task automatic test_reset();
    reset = 1'b1; rst4 = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0; rst4 = 1'b0;
    @(negedge clk);
    n_checks++; if (bif.state_dbg !== S_IDLE) begin n_fail++; $display("FAIL reset_state: got %0d expected %0d", bif.state_dbg, S_IDLE); end
    n_checks++; if (bif.cpu_rst !== 1'b1) begin n_fail++; $display("FAIL reset_cpu_rst: got %0b expected 1", bif.cpu_rst); end
    n_checks++; if (bif.cpu_en !== 1'b0) begin n_fail++; $display("FAIL reset_cpu_en: got %0b expected 0", bif.cpu_en); end
    n_checks++; if ({bif.busy, bif.halted, bif.snap_valid} !== 3'b000) begin n_fail++; $display("FAIL reset_flags: got %b expected 000", {bif.busy, bif.halted, bif.snap_valid}); end
    n_checks++; if (bif.cycle_count !== 32'd0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", bif.cycle_count); end
    n_checks++; if ({bif.pc_snap, bif.acc_snap} !== 27'd0) begin n_fail++; $display("FAIL reset_snap: got %0h/%0h expected 0/0", bif.pc_snap, bif.acc_snap); end
    n_checks++; if (bif4.state_dbg !== S_IDLE || bif4.cycle_count !== 4'd0) begin n_fail++; $display("FAIL reset_dut4: got state %0d count %0d expected 0/0", bif4.state_dbg, bif4.cycle_count); end
  endtask

  task automatic test_free_run();
    int en_cycles;
    int guard;
    @(negedge clk); bif.mode = 1'b0; bif.start = 1'b1;
    @(negedge clk); bif.start = 1'b0;
    n_checks++; if (bif.state_dbg !== S_CLR) begin n_fail++; $display("FAIL run_clr_state: got %0d expected %0d", bif.state_dbg, S_CLR); end
    n_checks++; if ({bif.cpu_rst, bif.cpu_en, bif.busy} !== 3'b101) begin n_fail++; $display("FAIL run_clr_outs: got %b expected 101", {bif.cpu_rst, bif.cpu_en, bif.busy}); end
    @(negedge clk);
    n_checks++; if (bif.cpu_en !== 1'b1) begin n_fail++; $display("FAIL run_latency: got cpu_en %0b expected 1", bif.cpu_en); end
    en_cycles = 0; guard = 0;
    while (bif.halted !== 1'b1 && guard < 30) begin
      if (bif.cpu_en === 1'b1) en_cycles++;
      guard++;
      @(negedge clk);
    end
    n_checks++; if (bif.halted !== 1'b1) begin n_fail++; $display("FAIL run_halt_timeout: got halted %0b expected 1", bif.halted); end
    n_checks++; if (en_cycles != 6) begin n_fail++; $display("FAIL run_en_cycles: got %0d expected 6", en_cycles); end
    n_checks++; if (bif.cycle_count !== 32'd6) begin n_fail++; $display("FAIL run_count: got %0d expected 6", bif.cycle_count); end
    n_checks++; if (bif.snap_valid !== 1'b0 || bif.cpu_en !== 1'b0) begin n_fail++; $display("FAIL run_halt_entry: got valid %0b en %0b expected 0/0", bif.snap_valid, bif.cpu_en); end
    @(negedge clk);
    n_checks++; if (bif.snap_valid !== 1'b1) begin n_fail++; $display("FAIL run_snap_valid: got %0b expected 1", bif.snap_valid); end
    n_checks++; if (bif.pc_snap !== 11'd6 || bif.acc_snap !== 16'h0066) begin n_fail++; $display("FAIL run_snap: got %0h/%0h expected 6/66", bif.pc_snap, bif.acc_snap); end
    n_checks++; if (bif.halted !== 1'b1 || bif.busy !== 1'b0) begin n_fail++; $display("FAIL run_halt_flags: got halted %0b busy %0b expected 1/0", bif.halted, bif.busy); end
  endtask

  task automatic test_single_step();
    int pulses;
    @(negedge clk); bif.mode = 1'b1; bif.start = 1'b1;
    @(negedge clk); bif.start = 1'b0;
    @(negedge clk);
    n_checks++; if (bif.state_dbg !== S_PAUSE || bif.busy !== 1'b0 || bif.cpu_en !== 1'b0) begin n_fail++; $display("FAIL step_pause: got state %0d busy %0b en %0b expected %0d/0/0", bif.state_dbg, bif.busy, bif.cpu_en, S_PAUSE); end
    n_checks++; if (bif.cycle_count !== 32'd0) begin n_fail++; $display("FAIL step_count0: got %0d expected 0", bif.cycle_count); end
    for (int k = 1; k <= 6; k++) begin
      bif.step = 1'b1;
      @(negedge clk); bif.step = 1'b0;
      n_checks++; if (bif.state_dbg !== S_STEP || bif.busy !== 1'b1) begin n_fail++; $display("FAIL step_in_step k=%0d: got state %0d busy %0b expected %0d/1", k, bif.state_dbg, bif.busy, S_STEP); end
      pulses = 0;
      for (int c = 0; c < 3; c++) begin
        if (bif.cpu_en === 1'b1) pulses++;
        @(negedge clk);
      end
      n_checks++; if (pulses != 1) begin n_fail++; $display("FAIL step_pulses k=%0d: got %0d expected 1", k, pulses); end
      n_checks++; if (bif.cycle_count !== 32'(k)) begin n_fail++; $display("FAIL step_count k=%0d: got %0d expected %0d", k, bif.cycle_count, k); end
      n_checks++; if (bif.pc_snap !== 11'(k) || bif.busy !== 1'b0) begin n_fail++; $display("FAIL step_pc_snap k=%0d: got %0d busy %0b expected %0d/0", k, bif.pc_snap, bif.busy, k); end
    end
    // PC now sits on the HLT word: with no step pulse the controller stays paused.
    repeat (3) @(negedge clk);
    n_checks++; if (bif.state_dbg !== S_PAUSE || bif.halted !== 1'b0 || bif.cpu_en !== 1'b0) begin n_fail++; $display("FAIL step_hlt_hold: got state %0d halted %0b en %0b expected %0d/0/0", bif.state_dbg, bif.halted, bif.cpu_en, S_PAUSE); end
    bif.step = 1'b1;
    @(negedge clk); bif.step = 1'b0;
    n_checks++; if (bif.state_dbg !== S_HALT || bif.halted !== 1'b1) begin n_fail++; $display("FAIL step_into_halt: got state %0d halted %0b expected %0d/1", bif.state_dbg, bif.halted, S_HALT); end
    n_checks++; if (bif.cycle_count !== 32'd6) begin n_fail++; $display("FAIL step_halt_count: got %0d expected 6", bif.cycle_count); end
  endtask

  task automatic test_mode_switch();
    int en_seen;
    int guard;
    @(negedge clk); bif.mode = 1'b0; bif.start = 1'b1;
    @(negedge clk); bif.start = 1'b0;
    @(negedge clk);
    en_seen = 0;
    for (int i = 0; i < 10; i++) begin
      if (bif.cpu_en === 1'b1) en_seen++;
      if (en_seen == 4) begin
        bif.mode = 1'b1;
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
    n_checks++; if (bif.state_dbg !== S_PAUSE || bif.cpu_en !== 1'b0) begin n_fail++; $display("FAIL mode_pause: got state %0d en %0b expected %0d/0", bif.state_dbg, bif.cpu_en, S_PAUSE); end
    n_checks++; if (bif.cycle_count !== 32'd4) begin n_fail++; $display("FAIL mode_count4: got %0d expected 4", bif.cycle_count); end
    repeat (2) @(negedge clk);
    n_checks++; if (bif.pc_snap !== 11'd4 || bif.acc_snap !== 16'h0044 || bif.snap_valid !== 1'b1) begin n_fail++; $display("FAIL mode_snap: got %0h/%0h/%0b expected 4/44/1", bif.pc_snap, bif.acc_snap, bif.snap_valid); end
    repeat (3) @(negedge clk);
    n_checks++; if (bif.pc_snap !== 11'd4 || bif.cycle_count !== 32'd4) begin n_fail++; $display("FAIL mode_hold: got pc_snap %0d count %0d expected 4/4", bif.pc_snap, bif.cycle_count); end
    bif.mode = 1'b0;
    @(negedge clk);
    n_checks++; if (bif.state_dbg !== S_RUN) begin n_fail++; $display("FAIL mode_resume: got %0d expected %0d", bif.state_dbg, S_RUN); end
    en_seen = 0; guard = 0;
    while (bif.halted !== 1'b1 && guard < 30) begin
      if (bif.cpu_en === 1'b1) en_seen++;
      guard++;
      @(negedge clk);
    end
    n_checks++; if (bif.halted !== 1'b1 || en_seen != 2) begin n_fail++; $display("FAIL mode_finish: got halted %0b en %0d expected 1/2", bif.halted, en_seen); end
    n_checks++; if (bif.cycle_count !== 32'd6) begin n_fail++; $display("FAIL mode_count6: got %0d expected 6", bif.cycle_count); end
  endtask

  task automatic test_start_step_collision();
    @(negedge clk); bif.mode = 1'b1; bif.start = 1'b1;
    @(negedge clk); bif.start = 1'b0;
    @(negedge clk); bif.step = 1'b1;
    @(negedge clk); bif.step = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++; if (bif.cycle_count !== 32'd1 || bif.snap_valid !== 1'b1) begin n_fail++; $display("FAIL coll_pre: got count %0d valid %0b expected 1/1", bif.cycle_count, bif.snap_valid); end
    bif.start = 1'b1; bif.step = 1'b1;
    @(negedge clk); bif.start = 1'b0; bif.step = 1'b0;
    n_checks++; if (bif.state_dbg !== S_CLR || bif.cpu_rst !== 1'b1 || bif.cpu_en !== 1'b0) begin n_fail++; $display("FAIL coll_clr: got state %0d rst %0b en %0b expected %0d/1/0", bif.state_dbg, bif.cpu_rst, bif.cpu_en, S_CLR); end
    @(negedge clk);
    n_checks++; if (bif.state_dbg !== S_PAUSE || bif.cpu_rst !== 1'b0) begin n_fail++; $display("FAIL coll_pause: got state %0d rst %0b expected %0d/0", bif.state_dbg, bif.cpu_rst, S_PAUSE); end
    n_checks++; if (bif.cycle_count !== 32'd0 || bif.snap_valid !== 1'b0 || bif.pc !== 11'd0) begin n_fail++; $display("FAIL coll_cleared: got count %0d valid %0b pc %0d expected 0/0/0", bif.cycle_count, bif.snap_valid, bif.pc); end
    @(negedge clk);
    n_checks++; if (bif.snap_valid !== 1'b1 || bif.pc_snap !== 11'd0 || bif.acc_snap !== 16'd0) begin n_fail++; $display("FAIL coll_snap: got %0b/%0h/%0h expected 1/0/0", bif.snap_valid, bif.pc_snap, bif.acc_snap); end
  endtask

  task automatic test_saturation();
    @(negedge clk); bif4.mode = 1'b0; bif4.start = 1'b1;
    @(negedge clk); bif4.start = 1'b0;
    repeat (20) @(negedge clk);
    n_checks++; if (bif4.cycle_count !== 4'd15 || bif4.cnt_sat_dbg !== 1'b1) begin n_fail++; $display("FAIL sat_count: got %0d sat %0b expected 15/1", bif4.cycle_count, bif4.cnt_sat_dbg); end
    n_checks++; if (bif4.state_dbg !== S_RUN || bif4.cpu_en !== 1'b1) begin n_fail++; $display("FAIL sat_running: got state %0d en %0b expected %0d/1", bif4.state_dbg, bif4.cpu_en, S_RUN); end
    rst4 = 1'b1;
    @(negedge clk);
    n_checks++; if (bif4.state_dbg !== S_IDLE || bif4.cpu_en !== 1'b0 || bif4.cycle_count !== 4'd0) begin n_fail++; $display("FAIL midrun_reset: got state %0d en %0b count %0d expected %0d/0/0", bif4.state_dbg, bif4.cpu_en, bif4.cycle_count, S_IDLE); end
    n_checks++; if (bif4.cpu_rst !== 1'b1 || bif4.busy !== 1'b0) begin n_fail++; $display("FAIL midrun_reset_flags: got rst %0b busy %0b expected 1/0", bif4.cpu_rst, bif4.busy); end
    rst4 = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) prog[i] = (i == 6) ? 16'h0000 : (16'h0800 | 16'(i));
    reset = 1'b1; rst4 = 1'b1;
    bif.start = 1'b0;  bif.step = 1'b0;  bif.mode = 1'b0;
    bif4.start = 1'b0; bif4.step = 1'b0; bif4.mode = 1'b0;
    test_reset();
    test_free_run();
    test_single_step();
    test_mode_switch();
    test_start_step_collision();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bip_exec_ctrl.md
Name: bip_exec_ctrl

Overview:
- Execution controller for the BIP system. It sits between the top level and the CPU.
- Drives the CPU clock-enable and CPU reset, and supports free-run and single-step modes.
- Detects the halt opcode on the fetched instruction and stops the CPU before that instruction executes.
- Counts executed cycles and snapshots PC/accumulator whenever the CPU is frozen, for debug/LED readout.

Parameters:
- len_addr, 11, program address width (PC).
- len_data, 16, instruction and accumulator width.
- len_opcode, 5, opcode field width; the opcode is instr[len_data-1 -: len_opcode].
- len_cycles, 32, cycle counter width.
- halt_opcode, 5'b00000, opcode value treated as HLT.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- start  input  1  single-cycle pulse; (re)starts the program from address 0
- step  input  1  single-cycle pulse; executes one instruction when paused
- mode  input  1  0 = free-run, 1 = single-step/pause
- instr  input  len_data  instruction currently presented by program memory
- pc  input  len_addr  CPU program counter
- acc  input  len_data  CPU accumulator
- cpu_en  output  1  CPU clock-enable (combinational from state and instr)
- cpu_rst  output  1  CPU reset request
- busy  output  1  high in CLR, RUN, STEP
- halted  output  1  high in HALT
- cycle_count  output  len_cycles  number of cycles with cpu_en=1
- pc_snap  output  len_addr  PC captured while frozen
- acc_snap  output  len_data  accumulator captured while frozen
- snap_valid  output  1  snapshot registers hold a frozen-CPU value

Behaviour:
- Reset (synchronous, active-high, at any point including mid-run):
  - state=IDLE, cpu_rst=1, cpu_en=0, busy=0, halted=0.
  - cycle_count=0, pc_snap=0, acc_snap=0, snap_valid=0.
- is_halt = (instr opcode field == halt_opcode).
- States and transitions:
  - IDLE: cpu_rst=1, cpu_en=0. start -> CLR.
  - CLR: one cycle. cpu_rst=1, cpu_en=0; clears cycle_count and snap_valid. Next state: mode=0 -> RUN, mode=1 -> PAUSE.
  - RUN: cpu_en = ~is_halt; cycle_count increments on each cycle with cpu_en=1.
    - is_halt -> HALT. The HLT instruction is never executed and not counted.
    - Otherwise mode=1 -> PAUSE. The current cycle still executes.
  - PAUSE: cpu_en=0.
    - step & ~is_halt -> STEP.
    - step & is_halt -> HALT.
    - mode=0 -> RUN.
    - is_halt with no step -> stay in PAUSE.
  - STEP: exactly one cycle with cpu_en=1, cycle_count+1, then -> PAUSE. step is ignored while in STEP.
  - HALT: cpu_en=0, halted=1. Stays until start or reset.
- Priority: start in any non-IDLE state (RUN, PAUSE, STEP, HALT) -> CLR, overriding step and mode in the same cycle.
- Outputs cpu_rst, busy and halted are registered-state decodes, with no glitch paths from inputs. cpu_en is the only combinational input-dependent output.
- Snapshot:
  - In every cycle with state in {PAUSE, HALT}, pc_snap<=pc and acc_snap<=acc.
  - snap_valid<=1 from the cycle after entering either state.
  - snap_valid<=0 in CLR and on reset. Snapshot values hold through RUN.
- cycle_count saturates at all-ones; no wrap.
- Latency: start pulse to first cpu_en=1 is 2 cycles in run mode (start edge -> CLR, CLR -> RUN).

Decomposition:
- Shared package bip_pkg holds:
  - state encoding localparams: IDLE, CLR, RUN, PAUSE, STEP, HALT (3-bit).
  - opcode field width and the HLT opcode constant, shared with the CPU decoder.
- One sub-module: bip_sat_counter (parametrised width; synchronous clear, enable, saturate flag), instantiated for cycle_count.

Test Plan:
- Reset held 3 cycles, then released -> IDLE, cpu_rst=1, all counters/snapshots 0, cpu_en=0.
- mode=0, start; program has 6 non-HLT instructions then HLT at address 6 -> cpu_en high 6 cycles starting 2 cycles after start; halted=1; cycle_count=6; pc_snap=6; snap_valid=1 one cycle after HALT entry.
- mode=1, start, then 3 step pulses spaced 4 cycles apart -> exactly 3 single-cycle cpu_en pulses; cycle_count=3; pc_snap follows 1, 2, 3 after each step; busy high only in CLR/STEP.
- Run mode, switch mode=1 after 4 executed cycles, then back to 0 -> PAUSE holds cycle_count=4 with stable snapshot; RUN then resumes and counting continues to HLT.
- start and step in the same cycle while in PAUSE -> CLR wins; cycle_count=0, snap_valid=0, cpu_rst=1 for one cycle.
- len_cycles=4, long loop without HLT -> cycle_count sticks at 15; reset asserted mid-RUN -> next cycle IDLE, cpu_en=0, cycle_count=0.
